uart_controller: RTL and testbench

Bus-mapped UART: responds on the system bus as a slave at the UART address prefix and drives the board serial pins, 8N1, LSB first. One-byte TX holding register feeds a TX shifter. An RX deserializer feeds a small RX FIFO. Status bits let polling software avoid stalls and detect lost or corrupt bytes.

---
 rtl/uart_controller_pkg.sv | 29 ++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_controller.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart_controller.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_controller_pkg.sv
// Shared UART definitions: register offsets, status bit positions, FSM state types.
// Pure declarations, no logic or timing.
package uart_controller_pkg;

   localparam logic [31:0] UART_REG_DATA   = 32'h0;
   localparam logic [31:0] UART_REG_STATUS = 32'h4;

   localparam int ST_TX_READY  = 0;
   localparam int ST_RX_AVAIL  = 1;
   localparam int ST_FRAME_ERR = 2;
   localparam int ST_OVERRUN   = 3;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   function automatic logic [31:0] status_word(input logic tx_ready,
                                               input logic rx_avail,
                                               input logic frame_err,
                                               input logic overrun);
      logic [31:0] w;
      w               = '0;
      w[ST_TX_READY]  = tx_ready;
      w[ST_RX_AVAIL]  = rx_avail;
      w[ST_FRAME_ERR] = frame_err;
      w[ST_OVERRUN]   = overrun;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes; head is visible combinationally, one-cycle push-to-head latency.
// A push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A pop frees the slot in the same edge, so a full FIFO can still accept.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_controller.sv
// Bus-mapped 8N1 UART: TX holding register + shifter, RX deserializer into a small FIFO.
// Reads never stall; a DATA write stalls while the holding register is full and the shifter is not taking it.
module uart_controller
   import uart_controller_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int RX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] data_wr,
   input  logic [3:0]  mask,
   output logic        stall,
   output logic [31:0] data_rd,
   output logic [31:0] data_rd_2,
   output logic        txd,
   input  logic        rxd
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

   if (DIV < 4) begin : g_bad_div
      $error("uart_controller: CLK_FREQ / BAUD must be at least 4");
   end
   if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_controller: RX_DEPTH must be a power of two >= 2");
   end

   // Bus decode
   logic w_is_data;
   logic w_is_status;
   logic w_wr_data;
   logic w_wr_acc;
   logic w_pop;
   logic w_status_rd;
   logic w_unused_bits;

   assign w_is_data     = (address[2] == UART_REG_DATA[2]);
   assign w_is_status   = (address[2] == UART_REG_STATUS[2]);
   assign w_wr_data     = write && w_is_data && mask[0];
   assign w_unused_bits = ^{address[31:3], address[1:0], data_wr[31:8], mask[3:1]};

   // TX
   tx_state_t     r_tx_state, w_tx_state_nxt;
   logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
   logic [2:0]    r_tx_bit, w_tx_bit_nxt;
   logic [7:0]    r_tx_shift, w_tx_shift_nxt;
   logic [7:0]    r_hold;
   logic          r_hold_full;
   logic          r_txd;
   logic          w_txd_nxt;
   logic          w_tx_take;
   logic          w_tx_bit_end;

   assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_cnt_nxt   = r_tx_cnt + CW'(1);
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_take      = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_cnt_nxt = '0;
            if (r_hold_full) begin
               w_tx_take      = 1'b1;
               w_tx_state_nxt = TX_START;
            end
         end
         TX_START: begin
            if (w_tx_bit_end) begin
               w_tx_state_nxt = TX_DATA;
               w_tx_cnt_nxt   = '0;
               w_tx_bit_nxt   = '0;
            end
         end
         TX_DATA: begin
            if (w_tx_bit_end) begin
               w_tx_cnt_nxt   = '0;
               w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
               w_tx_bit_nxt   = r_tx_bit + 3'd1;
               if (r_tx_bit == 3'd7) begin
                  w_tx_state_nxt = TX_STOP;
               end
            end
         end
         TX_STOP: begin
            // Reloading straight from the last stop cycle keeps consecutive frames gapless.
            if (w_tx_bit_end) begin
               w_tx_cnt_nxt = '0;
               if (r_hold_full) begin
                  w_tx_take      = 1'b1;
                  w_tx_state_nxt = TX_START;
               end else begin
                  w_tx_state_nxt = TX_IDLE;
               end
            end
         end
         default: w_tx_state_nxt = TX_IDLE;
      endcase
      if (w_tx_take) begin
         w_tx_shift_nxt = r_hold;
      end
   end

   always_comb begin
      case (w_tx_state_nxt)
         TX_START: w_txd_nxt = 1'b0;
         TX_DATA:  w_txd_nxt = w_tx_shift_nxt[0];
         default:  w_txd_nxt = 1'b1;
      endcase
   end

   assign stall    = w_wr_data && r_hold_full && !w_tx_take;
   assign w_wr_acc = w_wr_data && !stall;
   assign txd      = r_txd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_state  <= TX_IDLE;
         r_tx_cnt    <= '0;
         r_tx_bit    <= '0;
         r_tx_shift  <= '0;
         r_txd       <= 1'b1;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_txd      <= w_txd_nxt;
         if (w_wr_acc) begin
            r_hold      <= data_wr[7:0];
            r_hold_full <= 1'b1;
         end else if (w_tx_take) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   // RX
   rx_state_t     r_rx_state, w_rx_state_nxt;
   logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
   logic [2:0]    r_rx_bit, w_rx_bit_nxt;
   logic [7:0]    r_rx_shift, w_rx_shift_nxt;
   logic          r_rx_s1;
   logic          r_rx_s2;
   logic          w_rx_push;
   logic          w_ferr_set;
   logic          w_ovr_set;
   logic          w_rx_bit_end;
   logic          r_frame_err;
   logic          r_overrun;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic [7:0]    w_fifo_head;

   assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt + CW'(1);
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_push      = 1'b0;
      w_ferr_set     = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            w_rx_cnt_nxt = '0;
            if (!r_rx_s2) begin
               w_rx_state_nxt = RX_START;
            end
         end
         RX_START: begin
            // Mid start bit: a line back high means it was only a glitch.
            if (r_rx_cnt == HALF_LAST) begin
               w_rx_cnt_nxt   = '0;
               w_rx_bit_nxt   = '0;
               w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (w_rx_bit_end) begin
               w_rx_cnt_nxt   = '0;
               w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
               w_rx_bit_nxt   = r_rx_bit + 3'd1;
               if (r_rx_bit == 3'd7) begin
                  w_rx_state_nxt = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (w_rx_bit_end) begin
               w_rx_cnt_nxt   = '0;
               w_rx_push      = r_rx_s2;
               w_ferr_set     = !r_rx_s2;
               w_rx_state_nxt = RX_IDLE;
            end
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   assign w_pop       = read && w_is_data && !w_fifo_empty;
   assign w_status_rd = read && w_is_status;
   assign w_ovr_set   = w_rx_push && w_fifo_full && !w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1     <= 1'b1;
         r_rx_s2     <= 1'b1;
         r_rx_state  <= RX_IDLE;
         r_rx_cnt    <= '0;
         r_rx_bit    <= '0;
         r_rx_shift  <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_rx_s1    <= rxd;
         r_rx_s2    <= r_rx_s1;
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_shift <= w_rx_shift_nxt;
         // A new error on the clearing edge wins so it is never lost.
         if (w_ferr_set) begin
            r_frame_err <= 1'b1;
         end else if (w_status_rd) begin
            r_frame_err <= 1'b0;
         end
         if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end else if (w_status_rd) begin
            r_overrun <= 1'b0;
         end
      end
   end

   uart_rx_fifo #(
      .WIDTH (8),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_rx_push),
      .i_push_dat (w_rx_shift_nxt),
      .i_pop      (w_pop),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_head     (w_fifo_head)
   );

   always_comb begin
      if (w_is_status) begin
         data_rd = status_word(!r_hold_full, !w_fifo_empty, r_frame_err, r_overrun);
      end else begin
         data_rd = {24'b0, (w_fifo_empty ? 8'h00 : w_fifo_head)};
      end
   end

   assign data_rd_2 = '0;

endmodule

// File: tb/tb_uart_controller.sv
// Randomized bench for uart_controller at DIV = 8, checked against a byte-queue model of both directions.
module tb_uart_controller;

   localparam int DIV   = 8;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] data_wr;
   logic [3:0]  mask;
   logic        stall;
   logic [31:0] data_rd;
   logic [31:0] data_rd_2;
   logic        txd;
   logic        rxd;

   uart_controller #(
      .CLK_FREQ (80),
      .BAUD     (10),
      .RX_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .address   (address),
      .read      (read),
      .write     (write),
      .data_wr   (data_wr),
      .mask      (mask),
      .stall     (stall),
      .data_rd   (data_rd),
      .data_rd_2 (data_rd_2),
      .txd       (txd),
      .rxd       (rxd)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: bytes the line must carry, bytes software should read, sticky flags.
   logic [7:0] tx_exp[$];
   logic [7:0] rx_q[$];
   int         tx_starts[$];
   bit         m_ferr = 0;
   bit         m_ovr  = 0;
   bit         mon_en = 0;
   int         frames_done = 0;

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   // TX line monitor: every cycle of a frame is compared with the expected 8N1 waveform.
   logic [7:0] m_byte;
   int         m_t;
   bit         m_busy = 0;
   always @(negedge clk) begin
      if (!mon_en) begin
         m_busy = 0;
      end else if (m_busy) begin
         m_t++;
         chk("tx_bit", 32'(txd), 32'(frame_bit(m_byte, m_t / DIV)));
         if (m_t == 10*DIV - 1) begin
            m_busy = 0;
            frames_done++;
         end
      end else if (txd !== 1'b1) begin
         if (tx_exp.size() == 0) begin
            chk("tx_spurious", 32'(txd), 32'h1);
         end else begin
            m_byte = tx_exp.pop_front();
            m_busy = 1;
            m_t    = 0;
            tx_starts.push_back(cyc);
         end
      end
   end

   task automatic bus_wr(input logic [31:0] a, input logic [7:0] d, input logic [3:0] m,
                         output int acc_cyc, output int stalls);
      @(negedge clk);
      address = a;
      data_wr = $urandom;
      data_wr[7:0] = d;
      mask    = m;
      write   = 1'b1;
      #1;
      stalls = 0;
      while (stall === 1'b1 && stalls < 400) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (stalls >= 400) chk("wr_stall_timeout", 32'(stalls), 32'h0);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      write   = 1'b0;
      if (a[2] == 1'b0 && m[0] && stalls < 400) tx_exp.push_back(d);
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      read    = 1'b1;
      #1;
      d = data_rd;
      @(posedge clk);
      #1;
      read = 1'b0;
   endtask

   task automatic rd_data_chk(input string tag);
      logic [31:0] d;
      logic [31:0] e;
      e = (rx_q.size() != 0) ? 32'(rx_q.pop_front()) : 32'h0;
      bus_rd(32'h0, d);
      chk(tag, d, e);
   endtask

   task automatic rd_status_chk(input string tag, input bit chk_txr, input logic exp_txr);
      logic [31:0] d;
      logic [31:0] e;
      e    = '0;
      e[0] = exp_txr;
      e[1] = (rx_q.size() != 0);
      e[2] = m_ferr;
      e[3] = m_ovr;
      bus_rd(32'h4, d);
      if (!chk_txr) begin
         d[0] = 1'b0;
         e[0] = 1'b0;
      end
      chk(tag, d, e);
      m_ferr = 0;
      m_ovr  = 0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stopb);
      logic [9:0] f;
      f = {stopb, b, 1'b0};
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         rxd = f[k];
         repeat (DIV) @(negedge clk);
      end
      rxd = 1'b1;
      if (!stopb) m_ferr = 1;
      else if (rx_q.size() >= DEPTH) m_ovr = 1;
      else rx_q.push_back(b);
   endtask

   task automatic wait_tx_idle(input string tag);
      int n;
      n = 0;
      while ((tx_exp.size() != 0 || m_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 3000), 32'h1);
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          acc1, acc2, acc3, st1, st2, st3, n, fd;
      logic [31:0] d;
      rxd = 1'b1; address = '0; read = 1'b0; write = 1'b0; data_wr = '0; mask = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_txd", 32'(txd), 32'h1);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rd2_zero", data_rd_2, 32'h0);
      rst_n  = 1'b1;
      mon_en = 1;
      bus_rd(32'h4, d);
      chk("rst_status", d, 32'h1);
      rd_data_chk("rst_data");

      // Single byte: latency, waveform and tx_ready timing.
      tx_starts.delete();
      bus_wr(32'h0, 8'hA5, 4'hF, acc1, st1);
      chk("a5_stall", 32'(st1), 32'h0);
      @(negedge clk); address = 32'h4; #1;
      chk("a5_txrdy_n1", 32'(data_rd[0]), 32'h0);
      @(negedge clk); #1;
      chk("a5_txrdy_n2", 32'(data_rd[0]), 32'h1);
      wait_tx_idle("a5_done");
      chk("a5_nframes", 32'(tx_starts.size()), 32'h1);
      if (tx_starts.size() > 0) chk("a5_start_cyc", 32'(tx_starts[0]), 32'(acc1 + 1));

      // Three back-to-back bytes: third stalls until the first frame's end.
      tx_starts.delete();
      bus_wr(32'h0, 8'($urandom), 4'hF, acc1, st1);
      bus_wr(32'h0, 8'($urandom), 4'hF, acc2, st2);
      bus_wr(32'h0, 8'($urandom), 4'hF, acc3, st3);
      chk("b2b_acc2", 32'(acc2), 32'(acc1 + 1));
      chk("b2b_st2", 32'(st2), 32'h0);
      chk("b2b_st3_nz", 32'(st3 > 0), 32'h1);
      chk("b2b_acc3", 32'(acc3), 32'(acc1 + 1 + 10*DIV));
      wait_tx_idle("b2b_done");
      chk("b2b_nframes", 32'(tx_starts.size()), 32'h3);
      if (tx_starts.size() == 3) begin
         chk("b2b_gap1", 32'(tx_starts[1] - tx_starts[0]), 32'(10*DIV));
         chk("b2b_gap2", 32'(tx_starts[2] - tx_starts[1]), 32'(10*DIV));
      end

      // Ignored writes: masked-off DATA write and STATUS write must not transmit.
      bus_wr(32'h0, 8'($urandom), 4'hE, acc1, st1);
      bus_wr(32'h4, 8'($urandom), 4'hF, acc1, st1);
      repeat (2*DIV) @(negedge clk);
      rd_status_chk("ign_status", 1, 1'b1);

      // RX basics.
      send_rx(8'h3C, 1'b1);
      send_rx(8'h81, 1'b1);
      rd_status_chk("rx2_status", 1, 1'b1);
      rd_data_chk("rx2_d0");
      rd_data_chk("rx2_d1");
      rd_status_chk("rx2_status_after", 1, 1'b1);

      // Overrun.
      for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b1);
      rd_status_chk("ovr_status", 1, 1'b1);
      for (int i = 0; i < 5; i++) rd_data_chk("ovr_data");
      rd_status_chk("ovr_cleared", 1, 1'b1);

      // Frame error.
      send_rx(8'($urandom), 1'b0);
      rd_status_chk("ferr_status", 1, 1'b1);
      rd_status_chk("ferr_cleared", 1, 1'b1);
      rd_data_chk("ferr_nodata");

      // Glitch.
      @(negedge clk); rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (12*DIV) @(negedge clk);
      rd_status_chk("glitch_status", 1, 1'b1);
      rd_data_chk("glitch_nodata");

      // Random mix of both directions.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0, 1:    send_rx(8'($urandom), 1'($urandom_range(0, 7) != 0));
            2:       rd_data_chk("rnd_data");
            3:       rd_status_chk("rnd_status", 0, 1'b0);
            default: bus_wr(32'h0, 8'($urandom), 4'hF, acc1, st1);
         endcase
      end
      wait_tx_idle("rnd_tx_done");
      while (rx_q.size() != 0) rd_data_chk("rnd_drain");
      rd_status_chk("rnd_final_status", 1, 1'b1);

      // Reset in the middle of a frame, with a byte sitting in the RX FIFO.
      send_rx(8'($urandom), 1'b1);
      tx_starts.delete();
      bus_wr(32'h0, 8'($urandom), 4'hF, acc1, st1);
      n = 0;
      while (tx_starts.size() == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rstmid_started", 32'(tx_starts.size()), 32'h1);
      if (tx_starts.size() > 0) begin
         while (cyc < tx_starts[0] + 4*DIV + 2) @(negedge clk);
      end
      mon_en = 0;
      rst_n  = 1'b0;
      address = 32'h4;
      #1;
      chk("rstmid_txd", 32'(txd), 32'h1);
      chk("rstmid_status", data_rd, 32'h1);
      write = 1'b1; address = 32'h0; mask = 4'hF;
      #1;
      chk("rstmid_stall", 32'(stall), 32'h0);
      write = 1'b0;
      tx_exp.delete();
      rx_q.delete();
      m_ferr = 0;
      m_ovr  = 0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1;
      fd = frames_done;
      bus_wr(32'h0, 8'($urandom), 4'hF, acc1, st1);
      wait_tx_idle("rstmid_new_done");
      chk("rstmid_new_frame", 32'(frames_done - fd), 32'h1);
      rd_status_chk("rstmid_final", 1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
